// File: rtl/cluster_event_cdc_dst.sv
// Cluster-side reader of the gray-pointer async event FIFO: write-pointer sync, slot read, registered valid/ready output.
// Latency: SYNC_STAGES+1 edges from a writer pointer change to evt_valid_o; slots are released on pop, not on consumer accept.
module cluster_event_cdc_dst #(
   parameter int LOG_DEPTH   = 3,
   parameter int EVNT_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [LOG_DEPTH:0]                       async_wptr_i,
   input  logic [EVNT_WIDTH-1:0][2**LOG_DEPTH-1:0]  async_data_i,
   output logic [LOG_DEPTH:0]                       async_rptr_o,
   output logic                                     evt_valid_o,
   input  logic                                     evt_ready_i,
   output logic [EVNT_WIDTH-1:0]                    evt_data_o,
   output logic [LOG_DEPTH:0]                       occupancy_o,
   output logic                                     err_o
);

   localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH+1)'(1);
   localparam logic [LOG_DEPTH:0] DEPTH_P = (LOG_DEPTH+1)'(2**LOG_DEPTH);

   function automatic logic [LOG_DEPTH:0] bin2gray(input logic [LOG_DEPTH:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [LOG_DEPTH:0] gray2bin(input logic [LOG_DEPTH:0] g);
      logic [LOG_DEPTH:0] b;
      b[LOG_DEPTH] = g[LOG_DEPTH];
      for (int i = LOG_DEPTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [SYNC_STAGES-1:0][LOG_DEPTH:0] sync_q;
   logic [LOG_DEPTH:0]                  wptr_sync_g;
   logic [LOG_DEPTH:0]                  wptr_sync_b;
   logic [LOG_DEPTH:0]                  rptr_b;
   logic [LOG_DEPTH:0]                  rptr_nxt;
   logic [LOG_DEPTH:0]                  rptr_g_q;
   logic [LOG_DEPTH-1:0]                rd_idx;
   logic [EVNT_WIDTH-1:0]               rd_word;
   logic                                fifo_empty;
   logic                                pop;
   logic                                valid_q;
   logic [EVNT_WIDTH-1:0]               data_q;
   logic                                err_q;

   // Multi-flop synchronizer; only the last stage is ever observed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= async_wptr_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign wptr_sync_g = sync_q[SYNC_STAGES-1];
   assign wptr_sync_b = gray2bin(wptr_sync_g);

   // rptr_g_q always equals gray(rptr_b), so the empty test compares registered gray codes directly.
   assign fifo_empty = (wptr_sync_g == rptr_g_q);
   assign pop        = !fifo_empty && (!valid_q || evt_ready_i);
   assign rptr_nxt   = rptr_b + PTR_ONE;
   assign rd_idx     = rptr_b[LOG_DEPTH-1:0];

   // Storage arrives bit-major, so the word is gathered one bit plane at a time.
   always_comb begin
      rd_word = '0;
      for (int b = 0; b < EVNT_WIDTH; b++) begin
         rd_word[b] = async_data_i[b][rd_idx];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr_b   <= '0;
         rptr_g_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
      end else if (pop) begin
         rptr_b   <= rptr_nxt;
         rptr_g_q <= bin2gray(rptr_nxt);
         valid_q  <= 1'b1;
         data_q   <= rd_word;
      end else if (valid_q && evt_ready_i) begin
         valid_q  <= 1'b0;
      end
   end

   assign occupancy_o = wptr_sync_b - rptr_b;

   // More entries than the FIFO can hold means the pointers no longer describe the same ring.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (occupancy_o > DEPTH_P) begin
         err_q <= 1'b1;
      end
   end

   assign async_rptr_o = rptr_g_q;
   assign evt_valid_o  = valid_q;
   assign evt_data_o   = data_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_cluster_event_cdc_dst.sv
// Bench for cluster_event_cdc_dst: models the SoC writer and checks delivery against an in-order event queue.
module tb_cluster_event_cdc_dst;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0]      async_wptr;
   logic [7:0][7:0] async_data;
   logic [3:0]      async_rptr;
   logic            evt_valid;
   logic            evt_ready;
   logic [7:0]      evt_data;
   logic [3:0]      occupancy;
   logic            err;

   cluster_event_cdc_dst #(.LOG_DEPTH(3), .EVNT_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .async_wptr_i (async_wptr),
      .async_data_i (async_data),
      .async_rptr_o (async_rptr),
      .evt_valid_o  (evt_valid),
      .evt_ready_i  (evt_ready),
      .evt_data_o   (evt_data),
      .occupancy_o  (occupancy),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] mem [8];
   logic [3:0] wptr;
   logic [7:0] exp_q [$];
   logic       stall_prev;
   logic [7:0] stall_dat;
   logic [3:0] prev_rptr;
   logic       wrap_seen;
   logic       s_vld;
   logic [7:0] s_dat;
   int         n_written;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic drive();
      async_wptr = wptr ^ (wptr >> 1);
      for (int s = 0; s < 8; s++)
         for (int b = 0; b < 8; b++)
            async_data[b][s] = mem[s][b];
   endtask

   // One clock: drive at negedge, sample just after, before the next posedge.
   task automatic cycle(input logic rdy, input logic do_wr, input logic [7:0] wd);
      @(negedge clk);
      evt_ready = rdy;
      if (do_wr) begin
         mem[wptr[2:0]] = wd;
         wptr = wptr + 4'd1;
         exp_q.push_back(wd);
      end
      drive();
      #1;
      s_vld = evt_valid;
      s_dat = evt_data;
      if (stall_prev) begin
         check("stable_vld", 32'(evt_valid), 1);
         check("stable_dat", 32'(evt_data), 32'(stall_dat));
      end
      if (evt_valid && evt_ready) begin
         check("q_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("order", 32'(evt_data), 32'(exp_q.pop_front()));
      end
      stall_prev = evt_valid && !evt_ready;
      stall_dat  = evt_data;
      if (prev_rptr == 4'b1000 && async_rptr == 4'b0000) wrap_seen = 1'b1;
      prev_rptr = async_rptr;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      wptr = '0;
      for (int s = 0; s < 8; s++) mem[s] = '0;
      exp_q.delete();
      stall_prev = 1'b0;
      prev_rptr  = '0;
      evt_ready  = 1'b0;
      drive();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      wrap_seen = 1'b0;
      n_written = 0;

      // Reset and idle
      reset_dut();
      rst_n = 1'b0;
      #1;
      check("rst_vld", 32'(evt_valid), 0);
      check("rst_rptr", 32'(async_rptr), 0);
      check("rst_dat", 32'(evt_data), 0);
      rst_n = 1'b1;
      repeat (10) cycle(1'b1, 1'b0, 8'h00);
      check("idle_vld", 32'(evt_valid), 0);
      check("idle_rptr", 32'(async_rptr), 0);
      check("idle_occ", 32'(occupancy), 0);
      check("idle_err", 32'(err), 0);

      // Single event latency: pointer changes before edge k
      cycle(1'b1, 1'b1, 8'hA5);
      cycle(1'b1, 1'b0, 8'h00);                  // after edge k
      cycle(1'b1, 1'b0, 8'h00);                  // after edge k+1
      check("lat_early_vld", 32'(s_vld), 0);
      cycle(1'b1, 1'b0, 8'h00);                  // after edge k+2
      check("lat_vld", 32'(s_vld), 1);
      check("lat_dat", 32'(s_dat), 32'h A5);
      check("lat_rptr", 32'(async_rptr), 32'b0001);
      cycle(1'b1, 1'b0, 8'h00);                  // after edge k+3
      check("lat_drop_vld", 32'(s_vld), 0);

      // Backpressure fill of all 8 slots
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h10 + 8'(i));
      repeat (4) cycle(1'b0, 1'b0, 8'h00);
      check("bp_vld", 32'(evt_valid), 1);
      check("bp_dat", 32'(evt_data), 32'h10);
      check("bp_occ", 32'(occupancy), 7);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 8'h00);
         check("bp_no_gap", 32'(s_vld), 1);
         check("bp_seq", 32'(s_dat), 32'h10 + 32'(i));
      end
      cycle(1'b1, 1'b0, 8'h00);
      check("bp_drained", 32'(s_vld), 0);

      // Random stream across pointer wrap
      for (int c = 0; c < 3000; c++) begin
         logic rdy, wr;
         rdy = ($urandom_range(0, 3) != 0);
         wr  = (n_written < 40) && (4'(wptr - g2b(async_rptr)) < 4'd8) && ($urandom_range(0, 1) == 1);
         cycle(rdy, wr, 8'($urandom));
         if (wr) n_written++;
         if (n_written == 40 && exp_q.size() == 0 && !evt_valid) break;
      end
      check("wrap_written", 32'(n_written), 40);
      check("wrap_all_recv", 32'(exp_q.size()), 0);
      check("wrap_gray_seen", 32'(wrap_seen), 1);
      check("wrap_err", 32'(err), 0);
      check("wrap_occ", 32'(occupancy), 0);

      // Pointer corruption sets the sticky error
      reset_dut();
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      async_wptr = 4'b1101;                      // gray(9), before edge k
      @(negedge clk);                            // after edge k
      @(negedge clk); #1;                        // after edge k+1
      check("err_early", 32'(err), 0);
      @(negedge clk); #1;                        // after edge k+2
      check("err_set", 32'(err), 1);
      async_wptr = 4'b0000;
      repeat (5) @(negedge clk);
      #1;
      check("err_sticky", 32'(err), 1);
      reset_dut();
      #1;
      check("err_cleared", 32'(err), 0);

      // Asynchronous reset with data in flight
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h60 + 8'(i));
      repeat (4) cycle(1'b0, 1'b0, 8'h00);
      check("mid_pre_vld", 32'(evt_valid), 1);
      check("mid_pre_occ", 32'(occupancy), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_vld", 32'(evt_valid), 0);
      check("mid_dat", 32'(evt_data), 0);
      check("mid_rptr", 32'(async_rptr), 0);
      check("mid_occ", 32'(occupancy), 0);
      check("mid_err", 32'(err), 0);
      reset_dut();
      repeat (4) cycle(1'b1, 1'b0, 8'h00);
      check("post_vld", 32'(evt_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
